switch_input_port: RTL
======================

Name: switch_input_port

Overview:
- Producer side of the CPU's input path: supplies the operand the CPU consumes on its switch-input (inSignal) instruction.
- Synchronizes the 16 board switches and a raw "enter" push-button, and debounces the button.
- On each debounced press, latches the switch value into a one-entry buffer and presents it with a valid/consume handshake.
- Drives a stall so the program counter holds while the CPU requests input that has not arrived; sits between the board pins and the inSignal mux / PC hold logic.

Parameters:
- DATA_WIDTH, 16, width of switch bus and buffered word.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a button level change is accepted; minimum 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- switches  input  DATA_WIDTH  raw board switches, asynchronous to clock.
- button  input  1  raw enter push-button, active-high when pressed, bouncy.
- cpu_req  input  1  high while the CPU executes the input instruction.
- clear_overrun  input  1  synchronous pulse that clears overrun.
- in_data  output  DATA_WIDTH  buffered switch word, routed to the inSignal mux.
- in_valid  output  1  buffer holds an unconsumed word.
- stall  output  1  combinational: cpu_req & ~in_valid; drives PC hold.
- overrun  output  1  sticky: a press arrived while the buffer was full.

Behaviour:
- Reset (reset low, asynchronous): in_data=0, in_valid=0, overrun=0, synchronizers=0, debounce counter=0, stable button level=0, edge-history flop=0.
- Synchronization:
  - button and switches each pass through 2 flops; the outputs are btn_s and sw_s.
  - Only synchronized values are used internally.
- Debounce:
  - stable is the accepted button level.
  - When btn_s == stable: counter <= 0.
  - When btn_s != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - When btn_s != stable and counter == DEBOUNCE_CYCLES-1: stable <= btn_s and counter <= 0.
  - Any reversion before the count completes restarts the count from 0, so pulses shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press detect:
  - press = stable & ~stable_d, where stable_d is stable delayed one cycle. It is one cycle wide per debounced rising edge.
  - A release (falling stable) produces no event.
- Latency: for a clean raw rising edge on button, in_valid rises after exactly DEBOUNCE_CYCLES+3 rising clock edges.
- Buffer FSM, states EMPTY (in_valid=0) and FULL (in_valid=1):
  - EMPTY & press: in_data <= sw_s; go to FULL.
  - FULL & cpu_req & ~press: word consumed; go to EMPTY. in_data holds its last value.
  - FULL & cpu_req & press: consume and refill in the same edge. in_data <= sw_s, stay FULL, overrun unchanged.
  - FULL & ~cpu_req & press: in_data unchanged, overrun <= 1, stay FULL.
  - EMPTY & cpu_req: no state change; stall=1.
- Handshake: a transfer occurs on any rising edge where cpu_req & in_valid. The CPU samples in_data in that same cycle.
- Stall: stall = cpu_req & ~in_valid, with no register delay. It drops in the cycle in_valid rises.
- clear_overrun:
  - Sets overrun to 0 at the next edge.
  - If an overrun-causing press coincides with it, set wins and overrun=1.
- Switch changes without a press never alter in_data.
- A reset asserted mid-debounce or mid-stall discards the count and the buffer. A button still held after reset release is accepted as a new press once debounced.

Test Plan:
- Reset: hold reset=0 with button=1 and switches=16'hFFFF → all outputs 0. After release with DEBOUNCE_CYCLES=4, in_valid=1 and in_data=16'hFFFF exactly 7 edges later.
- Basic press: DEBOUNCE_CYCLES=4, switches=16'h00A5, button 0→1 held → in_valid rises on edge 7 with in_data=16'h00A5. Assert cpu_req one cycle → in_valid=0 next edge, stall=0 throughout.
- Bounce rejection: DEBOUNCE_CYCLES=4, button toggled 1,0,1,0 with 3-cycle high pulses, then held 1 → no valid during bouncing. Exactly one word is captured, 7 edges after the final rise.
- Stall: cpu_req=1 from cycle 0 with no press → stall=1 every cycle. Press with switches=16'h1234 → stall falls in the same cycle in_valid rises. Transfer happens at the next edge with in_data=16'h1234.
- Overrun: first press captures 16'h0001 with cpu_req=0. Second press with switches=16'h0002 → in_data stays 16'h0001 and overrun=1. Then pulse clear_overrun → overrun=0.
- Simultaneous consume and refill: FULL with 16'h0003; cpu_req high on the exact edge a press captures 16'h0004 → in_valid stays 1, in_data=16'h0004, overrun=0.

Source files
------------

// File: rtl/switch_input_port.sv
// switch_input_port: synchronizes switches and enter button, debounces the button,
// and buffers one switch word per press behind a valid/consume handshake with CPU stall.
module switch_input_port #(
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] switches,
    input  logic                  button,
    input  logic                  cpu_req,
    input  logic                  clear_overrun,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_valid,
    output logic                  stall,
    output logic                  overrun
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic [DATA_WIDTH-1:0] sw_meta_q, sw_s_q, in_data_q;
    logic                  btn_meta_q, btn_s_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  stable_q, stable_d, stable_dly_q;
    logic                  overrun_q, press;
    state_t                state_q;

    always_comb begin
        press    = stable_q & ~stable_dly_q;
        cnt_d    = (btn_s_q == stable_q || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        stable_d = (btn_s_q != stable_q && cnt_q == CNT_MAX) ? btn_s_q : stable_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sw_meta_q    <= '0;
            sw_s_q       <= '0;
            btn_meta_q   <= 1'b0;
            btn_s_q      <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sw_meta_q    <= switches;
            sw_s_q       <= sw_meta_q;
            btn_meta_q   <= button;
            btn_s_q      <= btn_meta_q;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
        end
    end

    // A press into a full buffer with no consume is dropped and flagged; that set beats clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            in_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (clear_overrun)
                overrun_q <= 1'b0;
            case (state_q)
                EMPTY: if (press) begin
                    in_data_q <= sw_s_q;
                    state_q   <= FULL;
                end
                FULL: if (cpu_req) begin
                    if (press)
                        in_data_q <= sw_s_q;
                    else
                        state_q <= EMPTY;
                end else if (press) begin
                    overrun_q <= 1'b1;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign in_data  = in_data_q;
    assign in_valid = (state_q == FULL);
    assign overrun  = overrun_q;
    assign stall    = cpu_req & ~in_valid;
endmodule
